// File: rtl/hsi_mse_accum_if.sv
// hsi_mse_accum_if
// Beat-in / result-out bundle for the HSI sum-of-squared-differences accumulator.
//   beats        : beats per vector, sampled on the first beat of a vector (0 means 1)
//   in_valid     : input beat valid
//   in_ready     : accumulator can take a beat
//   data_vctr_1  : spectrum A, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_vctr_2  : spectrum B, same packing as A
//   out_valid    : result valid
//   out_ready    : consumer takes the result
//   data_sum_out : accumulated sum of squared differences
//   sat          : result saturated, qualified by out_valid
// master = source/consumer side, slave = accumulator side.
interface hsi_mse_accum_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int LANES          = 4,
   parameter int BEAT_CNT_WIDTH = 8,
   parameter int ACC_WIDTH      = 40,
   parameter int WORD_WIDTH     = DATA_WIDTH*LANES
);
   logic [BEAT_CNT_WIDTH-1:0] beats;
   logic                      in_valid;
   logic                      in_ready;
   logic [WORD_WIDTH-1:0]     data_vctr_1;
   logic [WORD_WIDTH-1:0]     data_vctr_2;
   logic                      out_valid;
   logic                      out_ready;
   logic [ACC_WIDTH-1:0]      data_sum_out;
   logic                      sat;

   modport master (
      output beats, in_valid, data_vctr_1, data_vctr_2, out_ready,
      input  in_ready, out_valid, data_sum_out, sat
   );

   modport slave (
      input  beats, in_valid, data_vctr_1, data_vctr_2, out_ready,
      output in_ready, out_valid, data_sum_out, sat
   );
endinterface

// File: rtl/hsi_mse_accum.sv
// hsi_mse_accum
// Pipelined, saturating sum-of-squared-differences accumulator over multi-beat spectra.
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : hsi_mse_accum_if slave (beat input handshake, result output handshake)
// Pipeline: S1 lane diff -> S2 lane square -> S3 adder tree -> S4 accumulate.
// One result per vector is held until the consumer takes it.

// Per-lane S1/S2: registered A-B difference, then registered square of its magnitude.
module hsi_mse_lane #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic [2*DATA_WIDTH-1:0] sq
);
   logic [DATA_WIDTH:0]   diff_q;
   logic [DATA_WIDTH-1:0] mag;

   // |A-B| never exceeds 2^DATA_WIDTH-1, so the magnitude fits DATA_WIDTH bits
   assign mag = diff_q[DATA_WIDTH] ? (~diff_q[DATA_WIDTH-1:0] + DATA_WIDTH'(1))
                                   : diff_q[DATA_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff_q <= '0;
         sq     <= '0;
      end else begin
         diff_q <= {1'b0, a} - {1'b0, b};
         sq     <= (2*DATA_WIDTH)'(mag) * (2*DATA_WIDTH)'(mag);
      end
   end
endmodule

module hsi_mse_accum #(
   parameter int DATA_WIDTH     = 16,
   parameter int LANES          = 4,
   parameter int WORD_WIDTH     = DATA_WIDTH*LANES,
   parameter int BEAT_CNT_WIDTH = 8,
   parameter int SUM_WIDTH      = 2*DATA_WIDTH+$clog2(LANES),
   parameter int ACC_WIDTH      = 40
) (
   input  logic           clk,
   input  logic           rst,
   hsi_mse_accum_if.slave bus
);
   // vld_pipe[0]=S1 diff, [1]=S2 square, [2]=S3 tree sum, [3]=S4 acc updated
   localparam int STAGES = 3;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

   state_t                              state_q, state_d;
   logic                                in_rdy_c, accept, last_beat;
   logic [STAGES:0]                     vld_pipe, last_pipe;
   logic [BEAT_CNT_WIDTH-1:0]           cnt_q, beats_eff;
   logic [LANES-1:0][2*DATA_WIDTH-1:0]  sq;
   logic [SUM_WIDTH-1:0]                tree_sum, sum_q;
   logic [ACC_WIDTH-1:0]                acc_q;
   logic                                sat_q;
   logic [ACC_WIDTH:0]                  acc_nxt;

   // in_ready is forced low while reset is held, not just after the first edge
   assign bus.in_ready     = in_rdy_c & ~rst;
   assign accept           = bus.in_valid & bus.in_ready;
   assign beats_eff        = (bus.beats == '0) ? BEAT_CNT_WIDTH'(1) : bus.beats;
   assign bus.out_valid    = (state_q == HOLD);
   assign bus.data_sum_out = acc_q;
   assign bus.sat          = sat_q;

   hsi_mse_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane [LANES-1:0] (
      .clk (clk),
      .rst (rst),
      .a   (bus.data_vctr_1),
      .b   (bus.data_vctr_2),
      .sq  (sq)
   );

   always_comb begin
      tree_sum = '0;
      for (int i = 0; i < LANES; i++) tree_sum += SUM_WIDTH'(sq[i]);
   end

   // extra top bit catches the carry that triggers saturation
   assign acc_nxt = {1'b0, acc_q} + (ACC_WIDTH+1)'(sum_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_rdy_c  = 1'b0;
      last_beat = 1'b0;
      case (state_q)
         IDLE: begin
            in_rdy_c = 1'b1;
            if (accept) begin
               last_beat = (beats_eff == BEAT_CNT_WIDTH'(1));
               state_d   = last_beat ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            in_rdy_c = 1'b1;
            if (accept && cnt_q == BEAT_CNT_WIDTH'(1)) begin
               last_beat = 1'b1;
               state_d   = DRAIN;
            end
         end
         // only the tagged last beat leaving S4 ends the vector
         DRAIN:   if (vld_pipe[STAGES] && last_pipe[STAGES]) state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe  <= '0;
         last_pipe <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
         last_pipe <= {last_pipe[STAGES-1:0], last_beat};
         sum_q     <= tree_sum;
         // counter holds beats still expected after the one being accepted
         if (accept)
            cnt_q <= ((state_q == IDLE) ? beats_eff : cnt_q) - BEAT_CNT_WIDTH'(1);
         if (vld_pipe[STAGES-1]) begin
            if (acc_nxt[ACC_WIDTH] || sat_q) begin
               acc_q <= '1;
               sat_q <= 1'b1;
            end else begin
               acc_q <= acc_nxt[ACC_WIDTH-1:0];
            end
         end
         if (state_q == HOLD && bus.out_ready) begin
            acc_q <= '0;
            sat_q <= 1'b0;
         end
      end
   end
endmodule
